sha_digest_tx: RTL

//  Read side of the SHA3-512 core: captures the 512-bit digest when the core asserts its

---
 rtl/sha_digest_tx.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sha_digest_tx.sv
// sha_digest_tx: read side of the SHA3 core. Captures the digest on a rising edge of the
// core's sticky out_ready and streams it, most significant byte first, to a UART transmitter
// over a valid/ready byte handshake. Output is lowercase ASCII hex or raw bytes, optionally
// followed by CR LF.
//
// Ports:
//   clk           system clock, all logic on posedge
//   rst_n         synchronous reset, active low
//   digest        digest from the hash core, [DIGEST_W-1 -: 8] is the first byte
//   digest_valid  hash core out_ready (level)
//   tx_data       character to the transmitter
//   tx_valid      tx_data valid
//   tx_ready      transmitter accepts tx_data when tx_valid & tx_ready
//   busy          high from capture until the last char is accepted
//   done          one-cycle pulse the cycle after the last char is accepted
module sha_digest_tx #(
  parameter int unsigned DIGEST_W  = 512,
  parameter bit          HEX_MODE  = 1'b1,
  parameter bit          APPEND_NL = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DIGEST_W-1:0] digest,
  input  logic                digest_valid,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                done
);

  // Digest characters per transfer, excluding the CR LF trailer.
  localparam int unsigned NDig = HEX_MODE ? DIGEST_W / 4 : DIGEST_W / 8;
  localparam int unsigned CntW = $clog2(DIGEST_W / 4 + 1);

  typedef enum logic [1:0] {StIdle, StSend, StTrail, StFin} state_e;

  state_e              state_q, state_d;
  logic [DIGEST_W-1:0] digest_q, digest_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                dv_q;
  logic                tx_valid_q, tx_valid_d;
  logic [7:0]          tx_data_q, tx_data_d;

  logic                trigger;
  logic                accept;
  logic                load;
  logic [7:0]          next_char;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    logic [7:0] c;
    if (nib < 4'd10) begin
      c = 8'h30 + {4'h0, nib};
    end else begin
      c = 8'h57 + {4'h0, nib};
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      digest_q   <= '0;
      cnt_q      <= '0;
      dv_q       <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      digest_q   <= digest_d;
      cnt_q      <= cnt_d;
      dv_q       <= digest_valid;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    digest_d   = digest_q;
    cnt_d      = cnt_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;

    trigger   = digest_valid & ~dv_q;
    accept    = tx_valid_q & tx_ready;
    // A new char may be staged when nothing is pending or the pending one leaves this cycle.
    load      = ~tx_valid_q | accept;
    next_char = HEX_MODE ? hex_char(digest_q[DIGEST_W-1 -: 4]) : digest_q[DIGEST_W-1 -: 8];

    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d  = StSend;
          digest_d = digest;
          cnt_d    = '0;
        end
      end
      StSend: begin
        if (load) begin
          if (cnt_q != CntW'(NDig)) begin
            tx_valid_d = 1'b1;
            tx_data_d  = next_char;
            digest_d   = HEX_MODE ? (digest_q << 4) : (digest_q << 8);
            cnt_d      = cnt_q + CntW'(1);
          end else if (APPEND_NL) begin
            // Final digest char accepted: CR follows with no bubble.
            state_d    = StTrail;
            tx_valid_d = 1'b1;
            tx_data_d  = 8'h0D;
          end else begin
            state_d    = StFin;
            tx_valid_d = 1'b0;
          end
        end
      end
      StTrail: begin
        if (accept) begin
          if (tx_data_q == 8'h0D) begin
            tx_data_d = 8'h0A;
          end else begin
            state_d    = StFin;
            tx_valid_d = 1'b0;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d    = StIdle;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q == StSend) || (state_q == StTrail);
  assign done     = (state_q == StFin);

endmodule
